// File: rtl/parking_pkg.sv
// Shared parking-lot constants, gate state encoding and occupancy helpers.
// Used by the gate arbiter, the display blocks and the timing blocks.
package parking_pkg;

  localparam int NUM_SPOTS = 4;
  localparam int SPOT_W    = 2;
  localparam int CAP_W     = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    GUARD    = 2'd3
  } gate_state_t;

  // Number of free spots for a given occupancy vector.
  function automatic logic [CAP_W-1:0] free_count(input logic [NUM_SPOTS-1:0] occ);
    logic [CAP_W-1:0] n;
    n = CAP_W'(NUM_SPOTS);
    for (int i = 0; i < NUM_SPOTS; i++) n = n - CAP_W'(occ[i]);
    return n;
  endfunction

endpackage

// File: rtl/parking_spot_alloc.sv
// Lowest-index free spot finder: purely combinational priority encoder.
module parking_spot_alloc
  import parking_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] i_occ,
  output logic                 o_free_valid,
  output logic [SPOT_W-1:0]    o_free_idx
);

  // Scan high to low so the last hit, the lowest free index, wins.
  always_comb begin
    o_free_valid = 1'b0;
    o_free_idx   = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!i_occ[i]) begin
        o_free_valid = 1'b1;
        o_free_idx   = SPOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-door parking gate: arbitrates entry/exit requests, times the door
// open and guard phases, and owns occupancy/capacity/full status.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int DOOR_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [SPOT_W-1:0]    exit_spot,
  output logic                 enter_gnt,
  output logic                 exit_gnt,
  output logic                 enter_rej,
  output logic                 exit_rej,
  output logic [SPOT_W-1:0]    assigned_spot,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [CAP_W-1:0]     capacity,
  output logic                 full,
  output logic                 door_open,
  output logic                 busy
);

  localparam int CNT_MAX = (DOOR_CYCLES > GAP_CYCLES) ? DOOR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  gate_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_SPOTS-1:0] r_occ, w_occ_nxt;
  logic [SPOT_W-1:0]    r_spot, w_spot_nxt;
  logic [CAP_W-1:0]     r_cap;
  logic                 r_full, r_door, r_busy, w_door_nxt;
  logic                 r_rr_exit, w_rr_nxt;
  logic                 r_egnt, r_xgnt, r_erej, r_xrej;
  logic                 w_egnt, w_xgnt, w_erej, w_xrej;
  logic                 w_free_valid, w_serve_exit, w_serve_enter;
  logic [SPOT_W-1:0]    w_free_idx;

  parking_spot_alloc u_alloc (
    .i_occ        (r_occ),
    .o_free_valid (w_free_valid),
    .o_free_idx   (w_free_idx)
  );

  // Exit wins a tie when round-robin favours it; a reject still counts as served.
  assign w_serve_exit  = exit_req && (!enter_req || r_rr_exit);
  assign w_serve_enter = enter_req && !w_serve_exit;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_occ_nxt   = r_occ;
    w_spot_nxt  = r_spot;
    w_door_nxt  = r_door;
    w_rr_nxt    = r_rr_exit;
    w_egnt      = 1'b0;
    w_xgnt      = 1'b0;
    w_erej      = 1'b0;
    w_xrej      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_serve_exit) begin
          w_rr_nxt = 1'b0;
          if (r_occ[exit_spot]) begin
            w_xgnt               = 1'b1;
            w_occ_nxt[exit_spot] = 1'b0;
            w_state_nxt          = OPEN_OUT;
            w_cnt_nxt            = DOOR_LOAD;
            w_door_nxt           = 1'b1;
          end else begin
            w_xrej = 1'b1;
          end
        end else if (w_serve_enter) begin
          w_rr_nxt = 1'b1;
          if (w_free_valid) begin
            w_egnt                = 1'b1;
            w_occ_nxt[w_free_idx] = 1'b1;
            w_spot_nxt            = w_free_idx;
            w_state_nxt           = OPEN_IN;
            w_cnt_nxt             = DOOR_LOAD;
            w_door_nxt            = 1'b1;
          end else begin
            w_erej = 1'b1;
          end
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = GAP_LOAD;
          w_door_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GUARD: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_door_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_occ     <= '0;
      r_spot    <= '0;
      r_cap     <= CAP_W'(NUM_SPOTS);
      r_full    <= 1'b0;
      r_door    <= 1'b0;
      r_busy    <= 1'b0;
      r_rr_exit <= 1'b1;
      r_egnt    <= 1'b0;
      r_xgnt    <= 1'b0;
      r_erej    <= 1'b0;
      r_xrej    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_occ     <= w_occ_nxt;
      r_spot    <= w_spot_nxt;
      r_cap     <= free_count(w_occ_nxt);
      r_full    <= (free_count(w_occ_nxt) == '0);
      r_door    <= w_door_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_rr_exit <= w_rr_nxt;
      r_egnt    <= w_egnt;
      r_xgnt    <= w_xgnt;
      r_erej    <= w_erej;
      r_xrej    <= w_xrej;
    end
  end

  assign enter_gnt     = r_egnt;
  assign exit_gnt      = r_xgnt;
  assign enter_rej     = r_erej;
  assign exit_rej      = r_xrej;
  assign assigned_spot = r_spot;
  assign occupancy     = r_occ;
  assign capacity      = r_cap;
  assign full          = r_full;
  assign door_open     = r_door;
  assign busy          = r_busy;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: door timing, allocation, rejects,
// round-robin tie-break and asynchronous reset in the middle of a passage.
module tb_parking_gate_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_spot = 2'd0;
  logic       enter_gnt, exit_gnt, enter_rej, exit_rej;
  logic [1:0] assigned_spot;
  logic [3:0] occupancy;
  logic [2:0] capacity;
  logic       full, door_open, busy;

  int n_pass  = 0;
  int n_total = 0;

  parking_gate_arbiter #(.DOOR_CYCLES(8), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST),
    .enter_req(enter_req), .exit_req(exit_req), .exit_spot(exit_spot),
    .enter_gnt(enter_gnt), .exit_gnt(exit_gnt),
    .enter_rej(enter_rej), .exit_rej(exit_rej),
    .assigned_spot(assigned_spot), .occupancy(occupancy),
    .capacity(capacity), .full(full), .door_open(door_open), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) tick();
    chk("back_idle", busy, 1'b0);
  endtask

  task automatic do_enter(input logic [1:0] spot, input logic [3:0] occ);
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk("enter_gnt", enter_gnt, 1'b1);
    chk("enter_spot", assigned_spot, spot);
    chk("enter_occ", occupancy, occ);
    wait_idle();
  endtask

  task automatic do_exit(input logic [1:0] spot, input logic [3:0] occ);
    exit_req  = 1'b1;
    exit_spot = spot;
    tick();
    exit_req = 1'b0;
    chk("exit_gnt", exit_gnt, 1'b1);
    chk("exit_occ", occupancy, occ);
    wait_idle();
  endtask

  initial begin
    int door_cnt;
    int k;

    // Reset values
    #23;
    chk("rst_gnt", {enter_gnt, exit_gnt, enter_rej, exit_rej}, 4'b0000);
    chk("rst_spot", assigned_spot, 2'd0);
    chk("rst_occ", occupancy, 4'b0000);
    chk("rst_cap", capacity, 3'd4);
    chk("rst_full", full, 1'b0);
    chk("rst_door_busy", {door_open, busy}, 2'b00);
    #10 RST = 1'b1;
    tick();

    // First entry: grant, then door high exactly 8 cycles, 2 guard cycles
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk("e1_gnt", enter_gnt, 1'b1);
    chk("e1_spot", assigned_spot, 2'd0);
    chk("e1_occ", occupancy, 4'b0001);
    chk("e1_cap", capacity, 3'd3);
    chk("e1_busy", busy, 1'b1);
    door_cnt = (door_open === 1'b1) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (door_open === 1'b1) door_cnt++;
    end
    chk("e1_gnt_pulse", enter_gnt, 1'b0);
    tick();
    chk("e1_door_cycles", door_cnt, 8);
    chk("e1_guard1", {door_open, busy}, 2'b01);
    tick();
    chk("e1_guard2", {door_open, busy}, 2'b01);
    tick();
    chk("e1_idle", busy, 1'b0);

    // Fill the lot, then a fifth entry is refused
    do_enter(2'd1, 4'b0011);
    do_enter(2'd2, 4'b0111);
    do_enter(2'd3, 4'b1111);
    chk("full_flag", full, 1'b1);
    chk("full_cap", capacity, 3'd0);
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk("e5_rej", {enter_rej, enter_gnt}, 2'b10);
    tick();
    chk("e5_door", {door_open, busy, enter_rej}, 3'b000);
    chk("e5_occ", occupancy, 4'b1111);

    // Exit spot 2 from a full lot, next entry reuses spot 2
    do_exit(2'd2, 4'b1011);
    do_enter(2'd2, 4'b1111);
    exit_req = 1'b1; exit_spot = 2'd2;
    tick();
    exit_req = 1'b0;
    chk("x2_cap", capacity, 3'd1);
    chk("x2_full", full, 1'b0);
    wait_idle();
    do_exit(2'd1, 4'b1001);
    do_exit(2'd3, 4'b0001);

    // Exit of an empty spot is refused
    exit_req = 1'b1; exit_spot = 2'd3;
    tick();
    exit_req = 1'b0;
    chk("xbad_rej", {exit_rej, exit_gnt}, 2'b10);
    chk("xbad_occ", occupancy, 4'b0001);
    tick();
    chk("xbad_door", {door_open, busy}, 2'b00);

    // Entry served last so exit is due; simultaneous requests
    do_enter(2'd1, 4'b0011);
    enter_req = 1'b1; exit_req = 1'b1; exit_spot = 2'd0;
    tick();
    exit_req = 1'b0;
    chk("tie_xgnt", {exit_gnt, enter_gnt}, 2'b10);
    chk("tie_occ", occupancy, 4'b0010);
    chk("tie_cap", capacity, 3'd3);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (enter_gnt === 1'b1) begin
        k = i;
        break;
      end
    end
    enter_req = 1'b0;
    chk("tie_latency", k, 11);
    chk("tie_spot", assigned_spot, 2'd0);
    chk("tie_occ2", occupancy, 4'b0011);

    // Reset during the fourth open cycle of an entry
    wait_idle();
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk("rm_gnt", enter_gnt, 1'b1);
    chk("rm_spot", assigned_spot, 2'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("rm_door_before", door_open, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("rm_door", door_open, 1'b0);
    chk("rm_occ", occupancy, 4'b0000);
    chk("rm_cap", capacity, 3'd4);
    chk("rm_busy", busy, 1'b0);
    #10 RST = 1'b1;
    tick();
    chk("rm_idle", {busy, door_open}, 2'b00);
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk("rm_reentry", {enter_gnt, assigned_spot, occupancy}, {1'b1, 2'd0, 4'b0001});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
